// File: rtl/toggle_event_decoder_pkg.sv
// Shared constants and pending-state encoding for the toggle event decoder.
package toggle_event_pkg;

  localparam int unsigned DEPTH_DEFAULT = 8;
  localparam int unsigned CNT_W_DEFAULT = 8;
  localparam int unsigned PEND_W        = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FULL    = 2'd2
  } pend_state_e;

endpackage

// File: rtl/toggle_event_decoder_if.sv
// Event/acknowledge bundle between a toggle sender, the decoder and its consumer.
interface toggle_event_decoder_if
  import toggle_event_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
);

  logic              tog_in;
  logic              ev_pulse;
  logic              ev_valid;
  logic              ev_ready;
  logic              ack_tog;
  logic [CNT_W-1:0]  ev_count;
  logic [PEND_W-1:0] pend;
  logic              overflow;

  modport master (
    output tog_in,
    output ev_ready,
    input  ev_pulse,
    input  ev_valid,
    input  ack_tog,
    input  ev_count,
    input  pend,
    input  overflow
  );

  modport slave (
    input  tog_in,
    input  ev_ready,
    output ev_pulse,
    output ev_valid,
    output ack_tog,
    output ev_count,
    output pend,
    output overflow
  );

endinterface

// File: rtl/toggle_event_decoder_sync.sv
// Two-flop synchronizer plus history flop; det flags each level change of d_async.
module toggle_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic det
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_async;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign det = s2_q ^ s3_q;

endmodule

// File: rtl/toggle_event_decoder.sv
// Decodes toggle-encoded events into pulses, a pending-event queue count and a toggle acknowledge.
module toggle_event_decoder
  import toggle_event_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input logic                   clk,
  input logic                   rst,
  toggle_event_decoder_if.slave bus
);

  logic              det;
  logic              accept;
  pend_state_e       state;

  logic              pulse_q;
  logic [PEND_W-1:0] pend_q,  pend_d;
  logic              ovf_q,   ovf_d;
  logic              ack_q,   ack_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  toggle_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .d_async (bus.tog_in),
    .det     (det)
  );

  assign accept = (pend_q != '0) && bus.ev_ready;

  always_comb begin
    if (pend_q == '0) begin
      state = IDLE;
    end else if (pend_q == PEND_W'(DEPTH)) begin
      state = FULL;
    end else begin
      state = PENDING;
    end
  end

  // A det coinciding with an accept leaves pend untouched, so FULL never drops in that case.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    ack_d  = ack_q ^ accept;
    cnt_d  = cnt_q + CNT_W'(det);
    if (det && !accept) begin
      if (state == FULL) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (accept && !det) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_q <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pulse_q <= det;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ev_pulse = pulse_q;
  assign bus.ev_valid = (pend_q != '0);
  assign bus.ack_tog  = ack_q;
  assign bus.ev_count = cnt_q;
  assign bus.pend     = pend_q;
  assign bus.overflow = ovf_q;

endmodule
